bcd_digit_adder: RTL and testbench
==================================

Name: bcd_digit_adder

Overview:
- Single-digit BCD (8421) adder: adds two decimal digits plus a carry-in and produces a corrected BCD sum digit and a decimal carry-out.
- Building block for multi-digit ripple-carry BCD adders: digit i's cout feeds digit i+1's cin, and the last cout becomes the result MSB (e.g. 4 digits give a 17-bit result).
- Also provides an input-validity check and a sticky error flag, which are the only clocked logic.

Parameters:
- OUT_REG, default 0: 0 = sum/cout combinational (required for same-cycle ripple chaining); 1 = sum/cout registered, 1-cycle latency.

Ports:
- clk     input   1  system clock
- rst     input   1  synchronous, active-high reset
- cin     input   1  decimal carry-in from the lower digit
- a       input   4  BCD digit operand A (valid 0..9)
- b       input   4  BCD digit operand B (valid 0..9)
- sum     output  4  BCD sum digit (0..9 for valid inputs)
- cout    output  1  decimal carry-out to the next digit
- invalid output  1  combinational; 1 when a>9 or b>9
- err     output  1  sticky error; set on any clk edge where invalid=1

Behaviour:
- raw = a + b + cin, computed 5 bits wide (0..19 for valid inputs; 0..31 max).
- If raw > 9: cout=1, sum = (raw + 6) mod 16.
- If raw <= 9: cout=0, sum = raw[3:0].
- Invalid (non-BCD) inputs use the same rule; the output is deterministic but not meaningful. Example: a=15, b=15, cin=1 gives raw=31, sum=5, cout=1.
- invalid = (a>4'd9) | (b>4'd9), purely combinational and never registered.
- OUT_REG=0:
  - sum/cout are combinational from a, b, cin, with zero latency and no clock dependence.
  - rst does not affect them.
- OUT_REG=1:
  - sum/cout update on the rising edge of clk from the current inputs, giving 1-cycle latency.
  - rst=1 at an edge forces sum=0 and cout=0, and takes priority over new data.
- err:
  - Reset value is 0.
  - On each rising edge: if rst, err<=0; else if invalid, err<=1; else it holds.
  - rst and invalid in the same cycle: reset wins, so err=0.
  - Only rst clears err.
- No handshake, no state machine beyond the err flop (and the optional output flops).
- Only the 5-bit raw sum is arithmetic, so there is no overflow beyond cout.

Decomposition:
- Shared package bcd_pkg:
  - BCD_DIGIT_W = 4
  - BCD_MAX = 4'd9
  - BCD_CORR = 5'd6
  - typedef bcd_digit_t (4-bit logic)
- No sub-module. The digit adder is the leaf; multi-digit adders instantiate it N times in a ripple chain.

Test Plan:
- Exhaustive valid sweep, a,b in 0..9 and cin in 0..1 (200 vectors) -> {cout,sum} equals the BCD encoding of a+b+cin; invalid=0; err stays 0.
- Carry correction boundary: a=4, b=5, cin=0 -> sum=9, cout=0. a=4, b=5, cin=1 -> sum=0, cout=1. a=9, b=9, cin=1 -> sum=9, cout=1.
- Four-instance ripple chain, A=1234, B=5678, cin=0 -> digits (LSB first):
  - 4+8 -> sum 2, c 1
  - 3+7+1 -> sum 1, c 1
  - 2+6+1 -> sum 9, c 0
  - 1+5 -> sum 6, c 0
  - Result 06912, MSB carry 0.
- Invalid input: apply a=4'hA, b=0 for one cycle -> invalid=1 immediately, err=1 after the next edge. Return to valid inputs -> err stays 1. Assert rst for one edge -> err=0.
- Reset priority: rst=1 and a=4'hF in the same cycle -> err=0 after the edge.
- OUT_REG=1 build:
  - a=7, b=6, cin=0 -> sum=3, cout=1 one cycle later.
  - rst during the following cycle -> sum=0, cout=0 after that edge.

Source files
------------

// File: rtl/bcd_digit_adder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd_pkg : shared BCD digit types, constants and digit-add helpers      |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
package bcd_pkg;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX     = 4'd9;
  localparam logic [4:0] BCD_CORR    = 5'd6;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

  typedef struct packed {
    logic       cout;
    bcd_digit_t sum;
  } bcd_result_t;

  function automatic logic is_bcd(input bcd_digit_t d);
    return (d <= BCD_MAX);
  endfunction

  // Adding 6 skips the six unused 4-bit codes; only the low nibble is kept.
  function automatic bcd_result_t bcd_add(input bcd_digit_t a,
                                          input bcd_digit_t b,
                                          input logic       cin);
    logic [4:0]  raw;
    bcd_digit_t  adj;
    bcd_result_t res;
    raw      = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    adj      = raw[3:0] + BCD_CORR[3:0];
    res.cout = (raw > {1'b0, BCD_MAX});
    res.sum  = res.cout ? adj : raw[3:0];
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_adder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd_digit_adder_if : operand / result bundle of one BCD digit adder    |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
interface bcd_digit_adder_if;
  import bcd_pkg::*;

  logic       cin;
  bcd_digit_t a;
  bcd_digit_t b;
  bcd_digit_t sum;
  logic       cout;
  logic       invalid;
  logic       err;

  modport master (
    output cin, a, b,
    input  sum, cout, invalid, err
  );

  modport slave (
    input  cin, a, b,
    output sum, cout, invalid, err
  );

endinterface
`default_nettype wire

// File: rtl/bcd_digit_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd_digit_adder : one-digit BCD adder with validity check, sticky err  |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module bcd_digit_adder
  import bcd_pkg::*;
#(
  parameter int OUT_REG = 0
) (
  input  wire logic         clk,
  input  wire logic         rst,
  bcd_digit_adder_if.slave  bus
);

  bcd_result_t w_res;
  logic        w_invalid;
  logic        r_err;

  assign w_res     = bcd_add(bus.a, bus.b, bus.cin);
  assign w_invalid = ~is_bcd(bus.a) | ~is_bcd(bus.b);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_invalid) begin
      r_err <= 1'b1;
    end
  end

  assign bus.invalid = w_invalid;
  assign bus.err     = r_err;

  // Combinational form keeps a ripple chain single-cycle.
  generate
    if (OUT_REG == 0) begin : g_comb
      assign bus.sum  = w_res.sum;
      assign bus.cout = w_res.cout;
    end else begin : g_reg
      bcd_result_t r_res;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_res <= '0;
        end else begin
          r_res <= w_res;
        end
      end
      assign bus.sum  = r_res.sum;
      assign bus.cout = r_res.cout;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_bcd_digit_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bcd_digit_adder : vector table, ripple chain, registered variant    |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module tb_bcd_digit_adder;

  typedef struct packed {
    logic [3:0] sum;
    logic       cout;
    logic       inv;
  } exp_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       cout;
    logic       inv;
  } vec_t;

  localparam int N_VALID = 203;
  localparam int N_VEC   = 205;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];
  vec_t tv[N_VEC];

  always #5 clk = ~clk;

  bcd_digit_adder_if d0 ();
  bcd_digit_adder_if d1 ();
  bcd_digit_adder_if c0 ();
  bcd_digit_adder_if c1 ();
  bcd_digit_adder_if c2 ();
  bcd_digit_adder_if c3 ();

  bcd_digit_adder #(.OUT_REG(0)) u_d0 (.clk(clk), .rst(rst), .bus(d0));
  bcd_digit_adder #(.OUT_REG(1)) u_d1 (.clk(clk), .rst(rst), .bus(d1));
  bcd_digit_adder #(.OUT_REG(0)) u_c0 (.clk(clk), .rst(rst), .bus(c0));
  bcd_digit_adder #(.OUT_REG(0)) u_c1 (.clk(clk), .rst(rst), .bus(c1));
  bcd_digit_adder #(.OUT_REG(0)) u_c2 (.clk(clk), .rst(rst), .bus(c2));
  bcd_digit_adder #(.OUT_REG(0)) u_c3 (.clk(clk), .rst(rst), .bus(c3));

  logic [3:0] ch_a [4];
  logic [3:0] ch_b [4];
  logic       ch_cin;
  logic [3:0] ch_sum [4];
  logic       ch_cout [4];

  assign c0.a = ch_a[0];  assign c0.b = ch_b[0];  assign c0.cin = ch_cin;
  assign c1.a = ch_a[1];  assign c1.b = ch_b[1];  assign c1.cin = c0.cout;
  assign c2.a = ch_a[2];  assign c2.b = ch_b[2];  assign c2.cin = c1.cout;
  assign c3.a = ch_a[3];  assign c3.b = ch_b[3];  assign c3.cin = c2.cout;
  assign ch_sum[0] = c0.sum;  assign ch_cout[0] = c0.cout;
  assign ch_sum[1] = c1.sum;  assign ch_cout[1] = c1.cout;
  assign ch_sum[2] = c2.sum;  assign ch_cout[2] = c2.cout;
  assign ch_sum[3] = c3.sum;  assign ch_cout[3] = c3.cout;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic pop_exp(input string nm, output exp_t e);
    if (q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty got 0 expected 1 entry", nm);
      e = '0;
    end else begin
      e = q.pop_front();
    end
  endtask

  task automatic check_d0(input string nm);
    exp_t e;
    pop_exp(nm, e);
    chk({nm, ".sum"}, 32'(d0.sum), 32'(e.sum));
    chk({nm, ".cout"}, 32'(d0.cout), 32'(e.cout));
    chk({nm, ".invalid"}, 32'(d0.invalid), 32'(e.inv));
  endtask

  task automatic apply0(input logic [3:0] a, input logic [3:0] b, input logic cin, input exp_t e);
    @(negedge clk);
    d0.a = a; d0.b = b; d0.cin = cin;
    q.push_back(e);
    #1;
    check_d0("d0_vec");
  endtask

  task automatic run_chain(input int av, input int bv, input logic c);
    int   div;
    int   carry;
    int   t;
    int   got;
    exp_t e;
    @(negedge clk);
    div = 1;
    carry = int'(c);
    for (int i = 0; i < 4; i++) begin
      ch_a[i] = 4'((av / div) % 10);
      ch_b[i] = 4'((bv / div) % 10);
      t = (av / div) % 10 + (bv / div) % 10 + carry;
      q.push_back('{sum: 4'(t % 10), cout: (t >= 10), inv: 1'b0});
      carry = t / 10;
      div = div * 10;
    end
    ch_cin = c;
    #1;
    got = 0;
    div = 1;
    for (int i = 0; i < 4; i++) begin
      pop_exp("chain", e);
      chk($sformatf("chain_d%0d.sum", i), 32'(ch_sum[i]), 32'(e.sum));
      chk($sformatf("chain_d%0d.cout", i), 32'(ch_cout[i]), 32'(e.cout));
      got = got + int'(ch_sum[i]) * div;
      div = div * 10;
    end
    got = got + int'(ch_cout[3]) * 10000;
    chk("chain_result", 32'(got), 32'(av + bv + int'(c)));
  endtask

  initial begin
    exp_t e;
    int   k;
    int   t;

    d0.a = '0; d0.b = '0; d0.cin = 1'b0;
    d1.a = '0; d1.b = '0; d1.cin = 1'b0;
    ch_cin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ch_a[i] = '0;
      ch_b[i] = '0;
    end

    k = 0;
    for (int a = 0; a < 10; a++) begin
      for (int b = 0; b < 10; b++) begin
        for (int c = 0; c < 2; c++) begin
          t = a + b + c;
          tv[k] = '{4'(a), 4'(b), 1'(c), 4'(t % 10), (t >= 10), 1'b0};
          k++;
        end
      end
    end
    tv[200] = '{4'd4,  4'd5,  1'b0, 4'd9, 1'b0, 1'b0};
    tv[201] = '{4'd4,  4'd5,  1'b1, 4'd0, 1'b1, 1'b0};
    tv[202] = '{4'd9,  4'd9,  1'b1, 4'd9, 1'b1, 1'b0};
    tv[203] = '{4'd15, 4'd15, 1'b1, 4'd5, 1'b1, 1'b1};
    tv[204] = '{4'd10, 4'd0,  1'b0, 4'd0, 1'b1, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_d1.sum", 32'(d1.sum), 32'd0);
    chk("reset_d1.cout", 32'(d1.cout), 32'd0);
    chk("reset_d0.err", 32'(d0.err), 32'd0);
    chk("reset_d1.err", 32'(d1.err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < N_VEC; i++) begin
      if (i == N_VALID) begin
        @(posedge clk);
        #1;
        chk("sweep_err_clear", 32'(d0.err), 32'd0);
      end
      apply0(tv[i].a, tv[i].b, tv[i].cin, '{sum: tv[i].sum, cout: tv[i].cout, inv: tv[i].inv});
    end

    // err was set by the invalid vectors; a reset pulse clears it.
    @(negedge clk);
    d0.a = 4'd1; d0.b = 4'd2; d0.cin = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_clears_err", 32'(d0.err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    apply0(4'hA, 4'd0, 1'b0, '{sum: 4'd0, cout: 1'b1, inv: 1'b1});
    chk("inv_err_before_edge", 32'(d0.err), 32'd0);
    @(posedge clk);
    #1;
    chk("inv_err_set", 32'(d0.err), 32'd1);
    apply0(4'd3, 4'd3, 1'b0, '{sum: 4'd6, cout: 1'b0, inv: 1'b0});
    repeat (2) @(posedge clk);
    #1;
    chk("err_sticky", 32'(d0.err), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("err_rst_clear", 32'(d0.err), 32'd0);

    // Reset and invalid on the same edge; comb outputs ignore rst.
    @(negedge clk);
    d0.a = 4'hF; d0.b = 4'd0; d0.cin = 1'b0;
    q.push_back('{sum: 4'd5, cout: 1'b1, inv: 1'b1});
    #1;
    check_d0("comb_during_rst");
    @(posedge clk);
    #1;
    chk("rst_priority_err", 32'(d0.err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    d0.a = 4'd0;

    run_chain(1234, 5678, 1'b0);
    run_chain(9999, 0, 1'b1);
    run_chain(4567, 5432, 1'b1);

    // Registered variant: one-cycle latency and reset over data.
    @(negedge clk);
    d1.a = 4'd7; d1.b = 4'd6; d1.cin = 1'b0;
    q.push_back('{sum: 4'd3, cout: 1'b1, inv: 1'b0});
    #1;
    chk("reg_not_yet.sum", 32'(d1.sum), 32'd0);
    chk("reg_not_yet.cout", 32'(d1.cout), 32'd0);
    @(posedge clk);
    #1;
    pop_exp("reg", e);
    chk("reg_latency.sum", 32'(d1.sum), 32'(e.sum));
    chk("reg_latency.cout", 32'(d1.cout), 32'(e.cout));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("reg_rst.sum", 32'(d1.sum), 32'd0);
    chk("reg_rst.cout", 32'(d1.cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    d1.a = 4'd9; d1.b = 4'd9; d1.cin = 1'b1;
    q.push_back('{sum: 4'd9, cout: 1'b1, inv: 1'b0});
    @(posedge clk);
    #1;
    pop_exp("reg2", e);
    chk("reg_99.sum", 32'(d1.sum), 32'(e.sum));
    chk("reg_99.cout", 32'(d1.cout), 32'(e.cout));
    @(negedge clk);
    d1.a = 4'hB;
    #1;
    chk("reg_invalid_comb", 32'(d1.invalid), 32'd1);
    @(posedge clk);
    #1;
    chk("reg_err_set", 32'(d1.err), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
